reg_bank_mp: RTL and testbench
==============================

# reg_bank_mp

Parametrised multi-port register bank for the MIPS datapath, successor to the single-write, two-read register file. It provides NUM_RD combinational read ports with optional same-cycle write-to-read bypass and two write ports: port 0 for in-order ALU writeback, port 1 for out-of-band load/multicycle writeback. A per-register busy scoreboard lets decode stall on pending load-use hazards. A stack-pointer reset value is also supported.

## Interface
- DATA_W, 32, register width in bits
- DEPTH, 32, number of architectural registers (power of 2, ≥ 4); ADDR_W = $clog2(DEPTH), derived
- NUM_RD, 3, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only
- SP_IDX, 29, index of the stack pointer register
- SP_RST, 32'h0000_3FFC, reset value of register SP_IDX

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, packed the same way as rd_addr
- rd_busy  out  NUM_RD  1 = the register addressed on port k is pending
- wr0_en  in  1  ALU writeback enable
- wr0_addr  in  ADDR_W  ALU writeback address
- wr0_data  in  DATA_W  ALU writeback data
- wr1_en  in  1  load/multicycle writeback enable; also clears busy
- wr1_addr  in  ADDR_W  load writeback address
- wr1_data  in  DATA_W  load writeback data
- rsv_en  in  1  reserve: mark register rsv_addr busy
- rsv_addr  in  ADDR_W  register to reserve
- pend_cnt  out  ADDR_W+1  registered count of busy registers

## Operation
- Storage: DEPTH×DATA_W flops.
  - Register 0 is hardwired to 0. Writes and reservations to it are ignored, and it never reads busy.
- Write commit at rising clk:
  - If wrN_en and wrN_addr≠0, the register takes wrN_data.
  - Both ports targeting the same address: wr1 wins.
- Read path (combinational):
  - BYPASS=1: if wr1_en and wr1_addr==rd_addr (≠0), return wr1_data. Else if wr0_en and addresses match, return wr0_data. Else return the stored value.
  - BYPASS=0: always return the stored value.
- Busy scoreboard (one flop per register, bit 0 tied to 0):
  - Set on rsv_en when rsv_addr≠0.
  - Cleared at clk on wr1_en to that address.
  - rsv and wr1 to the same address in the same cycle: bit ends set (new reservation wins).
  - wr0 never changes busy bits.
  - rsv to an already-busy register: bit stays set, no error.
- rd_busy[k]:
  - Stored busy bit of rd_addr[k].
  - With BYPASS=1, the bit is masked to 0 when wr1_en clears that register this cycle and no rsv targets it this cycle.
- pend_cnt: registered population count of the busy vector after the cycle's updates. Range 0..DEPTH-1.
- Out-of-range is impossible by construction, since ADDR_W covers DEPTH exactly.

## Timing
- Reset (async assert, any time, including mid-write):
  - All registers go to 0 except SP_IDX, which goes to SP_RST.
  - All busy bits and pend_cnt go to 0.
  - Outputs reflect the reset state immediately.
- Release is synchronous to clk. The first write commits at the first rising edge after rst deasserts.
- Write latency: data is visible through storage on the cycle after the edge. With BYPASS=1 it is visible in the same cycle.
- Reserve latency: the busy bit is visible on rd_busy the cycle after rsv_en. pend_cnt updates on the same edge.
- Clear latency:
  - BYPASS=1: wr1 clears rd_busy in the same cycle.
  - BYPASS=0: wr1 clears rd_busy on the next cycle.
- No handshakes. All enables are single-cycle qualifiers, and every cycle's requests are accepted.

## Test plan
- Reset: drive rst while writes are active, then release. Required: read all addresses → 0 everywhere except reg 29 = 32'h0000_3FFC; pend_cnt=0; rd_busy=0.
- Write/read with bypass: wr0 to r5 with 32'hDEAD_BEEF, read r5 on all 3 ports in the same cycle. Required: BYPASS=1 → DEAD_BEEF in the same cycle; BYPASS=0 → old value, then DEAD_BEEF the next cycle.
- Collision: wr0 r7=32'h1111_1111 and wr1 r7=32'h2222_2222 in one cycle. Required: same-cycle read and the stored value are both 2222_2222.
- r0 protection: wr0, wr1 and rsv all to r0. Required: r0 reads 0, rd_busy=0, pend_cnt unchanged.
- Scoreboard: rsv r3, then rsv r4. Required: pend_cnt=2 and rd_busy set for r3 and r4.
  - Next, wr1 r3=32'h55 together with rsv r3 in one cycle. Required: r3 still busy, r3 = 0x55, pend_cnt=2.
  - Then wr1 r4. Required: pend_cnt=1.
- Async reset while r3 is busy and pend_cnt=1. Required: pend_cnt=0 and busy cleared without waiting for a clock edge.

Source files
------------

// File: rtl/reg_bank_mp.sv
// Multi-port register bank: NUM_RD combinational reads, two write ports,
// per-register busy scoreboard with registered pending count.
module reg_bank_mp #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 3,
  parameter int BYPASS = 1,
  parameter int SP_IDX = 29,
  parameter logic [DATA_W-1:0] SP_RST = 32'h0000_3FFC,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic [ADDR_W:0]          pend_cnt
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   cnt_d;

  logic wr0_ok;
  logic wr1_ok;
  logic rsv_ok;

  assign wr0_ok = wr0_en && (wr0_addr != '0);
  assign wr1_ok = wr1_en && (wr1_addr != '0);
  assign rsv_ok = rsv_en && (rsv_addr != '0);

  // wr1 is applied last so it wins an address collision
  always_comb begin
    mem_d = mem_q;
    if (wr0_ok) mem_d[wr0_addr] = wr0_data;
    if (wr1_ok) mem_d[wr1_addr] = wr1_data;
    mem_d[0] = '0;
  end

  // A same-cycle reservation overrides the wr1 clear
  always_comb begin
    busy_d = busy_q;
    if (wr1_ok) busy_d[wr1_addr] = 1'b0;
    if (rsv_ok) busy_d[rsv_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_d = cnt_d + (ADDR_W+1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= (i == SP_IDX) ? SP_RST : '0;
      end
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_cnt = cnt_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              hit0;
    logic              hit1;
    logic              clr;

    assign a    = rd_addr[k*ADDR_W +: ADDR_W];
    assign hit1 = (BYPASS != 0) && wr1_ok && (wr1_addr == a);
    assign hit0 = (BYPASS != 0) && wr0_ok && (wr0_addr == a);
    assign clr  = hit1 && !(rsv_ok && (rsv_addr == a));

    always_comb begin
      d = mem_q[a];
      if (hit1)      d = wr1_data;
      else if (hit0) d = wr0_data;
    end

    assign rd_data[k*DATA_W +: DATA_W] = d;
    assign rd_busy[k] = busy_q[a] & ~clr;
  end

endmodule

// File: tb/tb_reg_bank_mp.sv
// Directed bench for reg_bank_mp: bypass and non-bypass instances
// share one stimulus set.
module tb_reg_bank_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 3;
  localparam logic [31:0] SP = 32'h0000_3FFC;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data_b;
  logic [NR*DW-1:0] rd_data_n;
  logic [NR-1:0] rd_busy_b;
  logic [NR-1:0] rd_busy_n;
  logic          wr0_en;
  logic [AW-1:0] wr0_addr;
  logic [DW-1:0] wr0_data;
  logic          wr1_en;
  logic [AW-1:0] wr1_addr;
  logic [DW-1:0] wr1_data;
  logic          rsv_en;
  logic [AW-1:0] rsv_addr;
  logic [AW:0]   pend_b;
  logic [AW:0]   pend_n;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  reg_bank_mp #(.BYPASS(1)) dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pend_cnt(pend_b)
  );

  reg_bank_mp #(.BYPASS(0)) nb (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .pend_cnt(pend_n)
  );

  function automatic logic [DW-1:0] word(input logic [NR*DW-1:0] v,
                                         input int k);
    return v[k*DW +: DW];
  endfunction

  task automatic idle();
    wr0_en = 1'b0; wr1_en = 1'b0; rsv_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    rst = 1'b0;
    idle();
    rd_addr = '0;
    #2 rst = 1'b1;
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hABCD_0123;
    wr1_en = 1'b1; wr1_addr = 5'd29; wr1_data = 32'h7777_7777;
    rsv_en = 1'b1; rsv_addr = 5'd9;
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle();
    rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rd_addr = {AW'(a), AW'(a), AW'(a)};
      #1;
      e = (a == 29) ? SP : 32'h0;
      total++;
      if (word(rd_data_b, 0) !== e || word(rd_data_n, 2) !== e) begin
        bad++;
        $display("FAIL reset_r%0d got=%h/%h exp=%h", a,
                 word(rd_data_b, 0), word(rd_data_n, 2), e);
      end
      total++;
      if (rd_busy_b !== 3'b000 || rd_busy_n !== 3'b000) begin
        bad++;
        $display("FAIL reset_busy_r%0d got=%b/%b exp=000", a,
                 rd_busy_b, rd_busy_n);
      end
    end
    total++;
    if (pend_b !== 6'd0 || pend_n !== 6'd0) begin
      bad++;
      $display("FAIL reset_pend got=%0d/%0d exp=0", pend_b, pend_n);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEAD_BEEF;
    rd_addr = {5'd5, 5'd5, 5'd5};
    #1;
    for (int k = 0; k < NR; k++) begin
      total++;
      if (word(rd_data_b, k) !== 32'hDEAD_BEEF) begin
        bad++;
        $display("FAIL bypass_same_p%0d got=%h exp=deadbeef", k,
                 word(rd_data_b, k));
      end
      total++;
      if (word(rd_data_n, k) !== 32'h0) begin
        bad++;
        $display("FAIL nobypass_same_p%0d got=%h exp=0", k,
                 word(rd_data_n, k));
      end
    end
    @(negedge clk);
    idle();
    #1;
    for (int k = 0; k < NR; k++) begin
      total++;
      if (word(rd_data_b, k) !== 32'hDEAD_BEEF ||
          word(rd_data_n, k) !== 32'hDEAD_BEEF) begin
        bad++;
        $display("FAIL bypass_next_p%0d got=%h/%h exp=deadbeef", k,
                 word(rd_data_b, k), word(rd_data_n, k));
      end
    end
  endtask

  task automatic test_collision();
    @(negedge clk);
    wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h1111_1111;
    wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h2222_2222;
    rd_addr = {5'd7, 5'd7, 5'd7};
    #1;
    total++;
    if (word(rd_data_b, 1) !== 32'h2222_2222) begin
      bad++;
      $display("FAIL collide_same got=%h exp=22222222", word(rd_data_b, 1));
    end
    @(negedge clk);
    idle();
    #1;
    total++;
    if (word(rd_data_b, 2) !== 32'h2222_2222 ||
        word(rd_data_n, 0) !== 32'h2222_2222) begin
      bad++;
      $display("FAIL collide_stored got=%h/%h exp=22222222",
               word(rd_data_b, 2), word(rd_data_n, 0));
    end
  endtask

  task automatic test_r0();
    @(negedge clk);
    wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFFFF_FFFF;
    wr1_en = 1'b1; wr1_addr = 5'd0; wr1_data = 32'hEEEE_EEEE;
    rsv_en = 1'b1; rsv_addr = 5'd0;
    rd_addr = {5'd0, 5'd0, 5'd0};
    #1;
    total++;
    if (rd_data_b !== '0 || rd_busy_b !== 3'b000) begin
      bad++;
      $display("FAIL r0_same got=%h busy=%b exp=0", rd_data_b, rd_busy_b);
    end
    @(negedge clk);
    idle();
    #1;
    total++;
    if (rd_data_b !== '0 || rd_data_n !== '0 ||
        rd_busy_b !== 3'b000 || rd_busy_n !== 3'b000) begin
      bad++;
      $display("FAIL r0_after got=%h/%h busy=%b/%b exp=0",
               rd_data_b, rd_data_n, rd_busy_b, rd_busy_n);
    end
    total++;
    if (pend_b !== 6'd0 || pend_n !== 6'd0) begin
      bad++;
      $display("FAIL r0_pend got=%0d/%0d exp=0", pend_b, pend_n);
    end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    rsv_en = 1'b1; rsv_addr = 5'd3;
    @(negedge clk);
    rsv_addr = 5'd4;
    @(negedge clk);
    idle();
    rd_addr = {5'd5, 5'd4, 5'd3};
    #1;
    total++;
    if (pend_b !== 6'd2 || pend_n !== 6'd2) begin
      bad++;
      $display("FAIL sb_pend2 got=%0d/%0d exp=2", pend_b, pend_n);
    end
    total++;
    if (rd_busy_b !== 3'b011 || rd_busy_n !== 3'b011) begin
      bad++;
      $display("FAIL sb_busy got=%b/%b exp=011", rd_busy_b, rd_busy_n);
    end
    @(negedge clk);
    wr1_en = 1'b1; wr1_addr = 5'd3; wr1_data = 32'h55;
    rsv_en = 1'b1; rsv_addr = 5'd3;
    #1;
    total++;
    if (rd_busy_b[0] !== 1'b1 || word(rd_data_b, 0) !== 32'h55) begin
      bad++;
      $display("FAIL sb_rsvwr_same got=%b/%h exp=1/55",
               rd_busy_b[0], word(rd_data_b, 0));
    end
    @(negedge clk);
    idle();
    #1;
    total++;
    if (rd_busy_b[0] !== 1'b1 || rd_busy_n[0] !== 1'b1 ||
        word(rd_data_n, 0) !== 32'h55) begin
      bad++;
      $display("FAIL sb_rsvwr_after got=%b/%b/%h exp=1/1/55",
               rd_busy_b[0], rd_busy_n[0], word(rd_data_n, 0));
    end
    total++;
    if (pend_b !== 6'd2) begin
      bad++;
      $display("FAIL sb_pend_keep got=%0d exp=2", pend_b);
    end
    @(negedge clk);
    wr1_en = 1'b1; wr1_addr = 5'd4; wr1_data = 32'h66;
    #1;
    total++;
    if (rd_busy_b[1] !== 1'b0 || rd_busy_n[1] !== 1'b1) begin
      bad++;
      $display("FAIL sb_clr_same got=%b/%b exp=0/1",
               rd_busy_b[1], rd_busy_n[1]);
    end
    @(negedge clk);
    idle();
    #1;
    total++;
    if (pend_b !== 6'd1 || pend_n !== 6'd1) begin
      bad++;
      $display("FAIL sb_pend1 got=%0d/%0d exp=1", pend_b, pend_n);
    end
    total++;
    if (rd_busy_n !== 3'b001 || word(rd_data_n, 1) !== 32'h66) begin
      bad++;
      $display("FAIL sb_clr_next got=%b/%h exp=001/66",
               rd_busy_n, word(rd_data_n, 1));
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    rd_addr = {5'd29, 5'd5, 5'd3};
    rst = 1'b1;
    #1;
    total++;
    if (pend_b !== 6'd0 || pend_n !== 6'd0) begin
      bad++;
      $display("FAIL areset_pend got=%0d/%0d exp=0", pend_b, pend_n);
    end
    total++;
    if (rd_busy_b !== 3'b000 || rd_busy_n !== 3'b000) begin
      bad++;
      $display("FAIL areset_busy got=%b/%b exp=000", rd_busy_b, rd_busy_n);
    end
    total++;
    if (word(rd_data_b, 0) !== 32'h0 || word(rd_data_b, 1) !== 32'h0 ||
        word(rd_data_b, 2) !== SP) begin
      bad++;
      $display("FAIL areset_data got=%h exp=%h_0_0", rd_data_b, SP);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rd_addr = '0;
    wr0_addr = '0; wr0_data = '0;
    wr1_addr = '0; wr1_data = '0;
    rsv_addr = '0;
    idle();
    test_reset();
    test_bypass();
    test_collision();
    test_r0();
    test_scoreboard();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
